// File: rtl/ldl_round_pkg.sv
// Shared types for the grant-driven round mux: skid-buffer entry layout and packet state.
package ldl_round_pkg;
  localparam int SKID_DEPTH = 2;
  localparam int RND_DATA_W = 32;
  localparam int RND_BIN_W  = 3;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } pkt_state_t;

  typedef struct packed {
    logic [RND_DATA_W-1:0] data;
    logic [RND_BIN_W-1:0]  bin;
    logic                  first;
    logic                  last;
  } round_entry_t;
endpackage

// File: rtl/ldl_skid2.sv
// Generic 2-entry registered skid buffer; head entry is a register so pop_data is glitch-free.
module ldl_skid2
  import ldl_round_pkg::*;
#(
  parameter type T = round_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  output logic full,
  input  logic pop,
  output logic valid,
  output T     pop_data
);

  T           slot0;
  T           slot1;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign valid    = (count != 2'd0);
  assign full     = (count == 2'(SKID_DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & valid;
  assign pop_data = slot0;

  // Push while full is blocked, so a simultaneous push/pop only occurs with one entry held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: slot0 <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ldl_round_mux.sv
// Grant-driven data mux feeding a 2-entry skid buffer. Define LDL_ROUND_MUX_PKT_EN to hold
// the grant for a whole packet; otherwise the grant is released every beat.
module ldl_round_mux
  import ldl_round_pkg::*;
#(
  parameter int BIN_WIDTH  = RND_BIN_W,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = RND_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            grant_valid,
  input  logic [BIN_WIDTH-1:0]            grant_bin,
  output logic                            grant_ready,
  input  logic [REQ_WIDTH-1:0]            in_valid,
  input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic [REQ_WIDTH-1:0]            in_last,
  output logic [REQ_WIDTH-1:0]            in_ack,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [BIN_WIDTH-1:0]            out_bin,
  output logic                            out_first,
  output logic                            out_last
);

  logic                  full;
  logic                  take;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  first;
  logic                  release_grant;
  round_entry_t          push_entry;
  round_entry_t          head;

  assign sel_valid = in_valid[grant_bin];
  assign sel_last  = in_last[grant_bin];
  assign sel_data  = in_data[grant_bin*DATA_WIDTH +: DATA_WIDTH];

  // Gating uses only the registered fill level, never out_ready.
  assign take        = grant_valid & sel_valid & ~full;
  assign in_ack      = take ? (REQ_WIDTH'(1) << grant_bin) : '0;
  assign grant_ready = take & release_grant;

`ifdef LDL_ROUND_MUX_PKT_EN
  pkt_state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (take) begin
      state <= sel_last ? ST_IDLE : ST_BURST;
    end
  end

  assign first         = (state == ST_IDLE);
  assign release_grant = sel_last;
`else
  // Grants interleave channels beat by beat, so packet position is tracked per channel.
  logic [REQ_WIDTH-1:0] in_burst;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_burst <= '0;
    end else if (take) begin
      in_burst[grant_bin] <= ~sel_last;
    end
  end

  assign first         = ~in_burst[grant_bin];
  assign release_grant = 1'b1;
`endif

  always_comb begin
    push_entry       = '0;
    push_entry.data  = sel_data;
    push_entry.bin   = grant_bin;
    push_entry.first = first;
    push_entry.last  = sel_last;
  end

  ldl_skid2 #(
    .T(round_entry_t)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (take),
    .push_data(push_entry),
    .full     (full),
    .pop      (out_ready),
    .valid    (out_valid),
    .pop_data (head)
  );

  assign out_data  = head.data;
  assign out_bin   = head.bin;
  assign out_first = head.first;
  assign out_last  = head.last;

endmodule

// File: tb/tb_ldl_round_mux.sv
// Bench for ldl_round_mux: directed steps plus randomized traffic against a queue model.
module tb_ldl_round_mux;
  localparam int BW = 3;
  localparam int RW = 8;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             grant_valid;
  logic [BW-1:0]    grant_bin;
  logic             grant_ready;
  logic [RW-1:0]    in_valid;
  logic [RW*DW-1:0] in_data;
  logic [RW-1:0]    in_last;
  logic [RW-1:0]    in_ack;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [BW-1:0]    out_bin;
  logic             out_first;
  logic             out_last;

  always #5 clk = ~clk;

  ldl_round_mux #(.BIN_WIDTH(BW), .REQ_WIDTH(RW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .grant_valid(grant_valid), .grant_bin(grant_bin),
    .grant_ready(grant_ready), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ack(in_ack), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bin(out_bin), .out_first(out_first), .out_last(out_last)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            bin;
    bit            first;
    bit            last;
  } beat_t;

  beat_t         q[$];
  bit            open_pkt[RW];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [RW-1:0] obs_ack;
  logic          obs_gr;
  int            ack_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_open(input int b);
`ifdef LDL_ROUND_MUX_PKT_EN
    return open_pkt[0];
`else
    return open_pkt[b];
`endif
  endfunction

  task automatic set_open(input int b, input bit v);
`ifdef LDL_ROUND_MUX_PKT_EN
    open_pkt[0] = v;
`else
    open_pkt[b] = v;
`endif
  endtask

  task automatic rand_data();
    for (int c = 0; c < RW; c++) in_data[c*DW +: DW] = $urandom;
  endtask

  // Inputs are set at the falling edge; this checks, then models the rising edge.
  task automatic tick();
    bit            take_e;
    bit            pop_e;
    bit            gr_e;
    int            b;
    logic [DW-1:0] d;
    beat_t         nb;
    #1;
    b      = int'(grant_bin);
    take_e = grant_valid && in_valid[b] && (q.size() < 2);
    d      = in_data[b*DW +: DW];
`ifdef LDL_ROUND_MUX_PKT_EN
    gr_e = take_e && in_last[b];
`else
    gr_e = take_e;
`endif
    check("in_ack", 64'(in_ack), take_e ? (64'd1 << b) : 64'd0);
    check("grant_ready", 64'(grant_ready), 64'(gr_e));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_bin", 64'(out_bin), 64'(q[0].bin));
      check("out_first", 64'(out_first), 64'(q[0].first));
      check("out_last", 64'(out_last), 64'(q[0].last));
    end
    obs_ack = in_ack;
    obs_gr  = grant_ready;
    if (in_ack != '0) ack_cnt++;
    pop_e = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      for (int c = 0; c < RW; c++) open_pkt[c] = 1'b0;
    end else begin
      if (pop_e) void'(q.pop_front());
      if (take_e) begin
        nb.data  = d;
        nb.bin   = b;
        nb.first = !is_open(b);
        nb.last  = in_last[b];
        q.push_back(nb);
        set_open(b, !in_last[b]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; grant_valid = 1'b0; grant_bin = '0; in_valid = '0;
    in_last = '0; in_data = '0; out_ready = 1'b0; ack_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_bin", 64'(out_bin), 64'd0);
    check("rst_out_first", 64'(out_first), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_in_ack", 64'(in_ack), 64'd0);
    check("rst_grant_ready", 64'(grant_ready), 64'd0);
    rst_n = 1'b1;

    // Single-beat packet on channel 3
    grant_valid = 1'b1; grant_bin = 3'd3; in_valid = 8'h08; in_last = 8'h08;
    rand_data(); in_data[3*DW +: DW] = 32'hA5; out_ready = 1'b1;
    tick();
    check("t1_ack", 64'(obs_ack), 64'h08);
    check("t1_gr", 64'(obs_gr), 64'd1);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'hA5);
    check("t1_bin", 64'(out_bin), 64'd3);
    check("t1_first", 64'(out_first), 64'd1);
    check("t1_last", 64'(out_last), 64'd1);
    grant_valid = 1'b0; in_valid = '0; in_last = '0;
    tick();

    // Four-beat packet on channel 1 while channel 2 also has data
    ack_cnt = 0;
    for (int beat = 0; beat < 4; beat++) begin
      grant_valid = 1'b1; grant_bin = 3'd1; in_valid = 8'h06;
      in_last = (beat == 3) ? 8'h06 : 8'h04;
      rand_data();
      tick();
      check("pkt_ack", 64'(obs_ack), 64'h02);
`ifdef LDL_ROUND_MUX_PKT_EN
      check("pkt_gr", 64'(obs_gr), 64'(beat == 3));
`else
      check("pkt_gr", 64'(obs_gr), 64'd1);
`endif
    end
    check("pkt_ack_cnt", 64'(ack_cnt), 64'd4);
    grant_valid = 1'b0; in_valid = '0; in_last = '0;
    repeat (2) tick();

    // Backpressure: continuous grant with out_ready low
    out_ready = 1'b0; ack_cnt = 0;
    repeat (5) begin
      grant_valid = 1'b1; grant_bin = 3'd5; in_valid = 8'h20; in_last = 8'h00;
      rand_data();
      tick();
    end
    check("bp_takes", 64'(ack_cnt), 64'd2);
    check("bp_ack_blocked", 64'(obs_ack), 64'd0);
    out_ready = 1'b1; in_last = 8'h20;
    rand_data();
    tick();
    grant_valid = 1'b0; in_valid = '0; in_last = '0;
    repeat (3) tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Stall: grant on a channel with no data
    out_ready = 1'b0;
    grant_valid = 1'b1; grant_bin = 3'd6; in_valid = 8'h40; in_last = 8'h40;
    rand_data();
    tick();
    in_valid = 8'h01;
    repeat (2) begin
      rand_data();
      tick();
      check("stall_ack", 64'(obs_ack), 64'd0);
      check("stall_gr", 64'(obs_gr), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    grant_valid = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    repeat (2) tick();

    // Reset with two beats of an open packet buffered
    out_ready = 1'b0;
    repeat (2) begin
      grant_valid = 1'b1; grant_bin = 3'd4; in_valid = 8'h10; in_last = 8'h00;
      rand_data();
      tick();
    end
    check("rstmid_full", 64'(out_valid), 64'd1);
    grant_valid = 1'b0; in_valid = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_flushed", 64'(out_valid), 64'd0);
    grant_valid = 1'b1; grant_bin = 3'd4; in_valid = 8'h10; in_last = 8'h10; out_ready = 1'b1;
    rand_data();
    tick();
    check("rstmid_first", 64'(out_first), 64'd1);
    grant_valid = 1'b0; in_valid = '0; in_last = '0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      grant_valid = ($urandom_range(3) != 0);
      grant_bin   = 3'($urandom);
      in_valid    = 8'($urandom);
      in_last     = 8'($urandom);
      out_ready   = ($urandom_range(2) != 0);
      rst_n       = ($urandom_range(63) != 0);
      rand_data();
      tick();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ldl_round_mux.md
# ldl_round_mux

Grant-driven data multiplexer that sits directly downstream of the round-robin arbiter. It takes the arbiter's registered grant (valid plus binary index) and forwards beats from the granted one of REQ_WIDTH input channels into a 2-entry registered skid buffer. It returns a per-channel pop strobe to the source FIFOs and drives the arbiter's ready to release the grant.

## Interface
- BIN_WIDTH, 3, width of the channel index
- REQ_WIDTH, 1 << BIN_WIDTH, number of input channels
- DATA_WIDTH, 32, beat payload width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- grant_valid  in  1  arbiter grant valid
- grant_bin  in  BIN_WIDTH  granted channel index
- grant_ready  out  1  releases the grant; arbiter advances on the next edge
- in_valid  in  REQ_WIDTH  per-channel beat available
- in_data  in  REQ_WIDTH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  REQ_WIDTH  per-channel end-of-packet flag
- in_ack  out  REQ_WIDTH  one-hot pop strobe, at most one bit set per cycle
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  beat payload
- out_bin  out  BIN_WIDTH  source channel of the beat
- out_first  out  1  first beat of a packet
- out_last  out  1  last beat of a packet

## Operation
- take = grant_valid & in_valid[grant_bin] & (count < 2).
- in_ack = take ? (1 << grant_bin) : 0, combinational.
- On take, the selected data, grant_bin, last and first are pushed into the skid buffer.
- Skid buffer: 2 entries, count 0..2.
  - Pop when out_valid & out_ready.
  - A simultaneous push and pop keeps count unchanged and preserves order.
  - Push at count 2 is impossible by construction.
- State machine, two states:
  - IDLE: next beat is a packet start, first=1. A take with last=0 moves to BURST; a take with last=1 stays in IDLE.
  - BURST: first=0. A take with last=1 returns to IDLE.
- grant_ready = take & release, where release is defined under Configuration.
- If grant_valid is high and in_valid[grant_bin] is low, the block stalls. There is no take, no ack and no grant release.
- grant_bin is sampled only while grant_valid=1. Otherwise it is ignored.

## Timing
- Reset values: out_valid=0, count=0, state=IDLE, out_data/out_bin/out_first/out_last=0.
- in_ack and grant_ready are 0 whenever grant_valid=0.
- Latency: a take at edge n gives out_valid=1 after edge n, provided the buffer was empty.
- Throughput: 1 beat/cycle when out_ready=1 is held.
- Reset mid-packet: the buffer is flushed and state returns to IDLE. The partial packet is dropped downstream and is not resent.
- There is no combinational path from out_ready to in_ack or grant_ready; gating depends on registered count only.

## Configuration
- LDL_ROUND_MUX_PKT_EN defined: release = chosen beat's in_last. The grant is held for the whole packet, so packets from different channels never interleave.
- LDL_ROUND_MUX_PKT_EN undefined:
  - release = 1, giving beat-level round-robin.
  - in_last is still forwarded to out_last, and out_first still tracks per-packet state.
  - The FSM state is kept per channel: a REQ_WIDTH-bit in_burst vector indexed by grant_bin.

## Structure
- Shared package ldl_round_pkg:
  - typedef of the skid-buffer entry struct {data, bin, first, last}
  - localparam SKID_DEPTH = 2
- One sub-module ldl_skid2: a generic 2-entry registered skid buffer with push/full, pop/valid and a parameterised payload type. It is reused elsewhere.

## Test plan
- Reset, then grant_valid=1, grant_bin=3, in_valid=0x08, in_last[3]=1, in_data ch3=0xA5 with out_ready=1. Expect in_ack=0x08 and grant_ready=1 in the same cycle. One cycle later expect out_data=0xA5, out_bin=3, out_first=1, out_last=1.
- PKT_EN: a 4-beat packet on ch1 while ch2 has valid data. Expect grant_ready only on beat 4, in_ack=0x02 four times, and no ch2 beat in between.
- PKT_EN undefined: same stimulus. Expect grant_ready on every beat. out_first=1 only on ch1 beat 1 and out_last=1 only on beat 4.
- out_ready=0 for 5 cycles with a continuous grant. Expect exactly 2 takes, then in_ack=0. After out_ready=1, expect beats in order with no loss or duplicates.
- grant_valid=1 with in_valid[grant_bin]=0. Expect in_ack=0, grant_ready=0 and out_valid unchanged.
- Assert rst_n=0 for one cycle during a BURST with 2 beats buffered. Expect out_valid=0 next cycle. The next packet's first beat must carry out_first=1.
